// File: rtl/usb2_ep_tx_reader.sv
// Streams one packet out of the endpoint RAM: issues registered read addresses,
// captures the synchronous-RAM data into a 2-entry buffer and presents it as a valid/ready byte stream.
module usb2_ep_tx_reader #(
  parameter int ADR_W = 10,
  parameter int DAT_W = 8
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             start,
  input  logic [ADR_W-1:0] start_adr,
  input  logic [ADR_W:0]   len,
  input  logic             abort,
  output logic [ADR_W-1:0] ram_adr,
  input  logic [DAT_W-1:0] ram_dat,
  output logic [DAT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start; zero-length packets complete here
  // FETCH | read addresses still being issued to the RAM
  // DRAIN | all reads issued; emptying pipeline and buffer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADR_W:0] CNT_ONE = (ADR_W+1)'(1);

  state_t           state;
  state_t           state_nxt;
  logic [ADR_W:0]   fetch_cnt;
  logic [ADR_W:0]   out_cnt;
  logic [DAT_W-1:0] buf1;
  logic             vld1;
  logic             in_flight;
  logic [1:0]       credit;
  logic             pop;
  logic             last_pop;
  logic             accept;
  logic             issue;

  assign pop      = out_valid & out_ready;
  assign last_pop = pop & out_last;
  assign accept   = (state == IDLE) & start & ~abort;
  assign out_last = out_valid & (out_cnt == CNT_ONE);
  assign busy     = (state != IDLE);

  // The byte leaving this cycle frees its slot, which keeps one byte per cycle
  // flowing through the two-cycle RAM read path without ever exceeding two entries.
  assign credit = 2'(out_valid) + 2'(vld1) + 2'(in_flight);
  assign issue  = (state == FETCH) & ~abort &
                  ((credit < 2'd2) | (pop & (credit == 2'd2)));

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (len != '0)) state_nxt = FETCH;
      FETCH:   if (issue && (fetch_cnt == CNT_ONE)) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      ram_adr   <= '0;
      fetch_cnt <= '0;
      out_cnt   <= '0;
      in_flight <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      if (abort) begin
        in_flight <= 1'b0;
        fetch_cnt <= '0;
        out_cnt   <= '0;
      end else if (accept) begin
        ram_adr   <= start_adr;
        fetch_cnt <= len;
        out_cnt   <= len;
        done      <= (len == '0);
      end else begin
        if (issue) begin
          ram_adr   <= ram_adr + 1'b1;
          fetch_cnt <= fetch_cnt - 1'b1;
        end
        if (pop) out_cnt <= out_cnt - 1'b1;
        if (last_pop) done <= 1'b1;
      end
    end
  end

  // Head entry is the output register itself; buf1 only fills while the head is stalled.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      buf1      <= '0;
      vld1      <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
      vld1      <= 1'b0;
    end else if (pop) begin
      if (vld1) begin
        out_data <= buf1;
        vld1     <= in_flight;
        if (in_flight) buf1 <= ram_dat;
      end else begin
        out_valid <= in_flight;
        if (in_flight) out_data <= ram_dat;
      end
    end else if (!out_valid) begin
      out_valid <= in_flight;
      if (in_flight) out_data <= ram_dat;
    end else if (in_flight) begin
      buf1 <= ram_dat;
      vld1 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb2_ep_tx_reader.sv
// Directed bench for usb2_ep_tx_reader with a synchronous RAM model and
// hand-derived timing expectations relative to the start-accepting edge.
module tb_usb2_ep_tx_reader;
  localparam int ADR_W = 10;
  localparam int DAT_W = 8;
  localparam int DEPTH = 1024;

  logic             rd_clk = 1'b0;
  logic             rd_rst = 1'b1;
  logic             start = 1'b0;
  logic [ADR_W-1:0] start_adr = '0;
  logic [ADR_W:0]   len = '0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b0;
  logic [ADR_W-1:0] ram_adr;
  logic [DAT_W-1:0] ram_dat;
  logic [DAT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             done;

  logic [7:0] mem [DEPTH];
  int checks = 0;
  int failures = 0;

  // results gathered by drive_packet
  logic [7:0]       got_data[$];
  logic             got_last[$];
  int               n_done;
  int               stall_err;
  int               first_valid_iter;
  int               done_iter;
  logic             seen_valid;
  logic             seen_busy;
  logic             post_abort_valid;
  logic             post_abort_busy;
  logic             timed_out;
  logic [ADR_W-1:0] adr_iter0;

  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) ram_dat <= mem[ram_adr];

  usb2_ep_tx_reader #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .start_adr(start_adr),
    .len(len), .abort(abort), .ram_adr(ram_adr), .ram_dat(ram_dat),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  function automatic logic [7:0] exp_byte(input int adr, input int n);
    return mem[(adr + n) % DEPTH];
  endfunction

  // Iteration 0 is the negedge right after the edge that accepts start.
  task automatic drive_packet(input int adr, input int l, input bit rnd, input int abort_after);
    int iter, ntx, budget, tail;
    logic pv, pr, pl, r, v, la, dn, b;
    logic [7:0] pd, d;
    bit abort_pending, abort_sent, finished;
    got_data.delete();
    got_last.delete();
    n_done = 0; stall_err = 0; first_valid_iter = -1; done_iter = -1;
    seen_valid = 0; seen_busy = 0; post_abort_valid = 0; post_abort_busy = 0; timed_out = 0;
    budget = 8 * l + 40;
    @(negedge rd_clk);
    start = 1'b1; start_adr = adr[ADR_W-1:0]; len = l[ADR_W:0]; out_ready = 1'b0;
    @(negedge rd_clk);
    start = 1'b0;
    adr_iter0 = ram_adr;
    pv = 0; pr = 0; pd = '0; pl = 0; ntx = 0; tail = 0; iter = 0;
    abort_pending = 0; abort_sent = 0; finished = 0;
    while (!finished) begin
      v = out_valid; d = out_data; la = out_last; dn = done; b = busy;
      if (pv && !pr && !abort && (!v || d !== pd || la !== pl)) stall_err++;
      if (v) begin
        seen_valid = 1;
        if (first_valid_iter < 0) first_valid_iter = iter;
      end
      if (b) seen_busy = 1;
      if (dn) begin
        n_done++;
        if (done_iter < 0) done_iter = iter;
      end
      if (abort) begin
        abort = 1'b0;
        post_abort_valid = v;
        post_abort_busy = b;
      end
      r = abort_pending ? 1'b0 : (rnd ? ($urandom_range(1, 0) != 0) : 1'b1);
      if (abort_pending) begin
        abort = 1'b1;
        abort_pending = 0;
        abort_sent = 1;
      end
      out_ready = r;
      if (v && r) begin
        got_data.push_back(d);
        got_last.push_back(la);
        ntx++;
        if (abort_after > 0 && ntx == abort_after) abort_pending = 1;
      end
      pv = v; pr = r; pd = d; pl = la;
      if (done_iter >= 0 || (abort_sent && !abort)) tail++;
      if (tail > 6) finished = 1;
      if (iter > budget) begin
        timed_out = 1;
        finished = 1;
      end
      iter++;
      @(negedge rd_clk);
    end
    out_ready = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge rd_clk);
    start = 1'b1; start_adr = 10'h055; len = 11'd4;
    @(negedge rd_clk);
    @(negedge rd_clk);
    checks++; if (ram_adr !== '0) begin failures++; $display("FAIL reset_ram_adr got=%h exp=0", ram_adr); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    start = 1'b0;
    rd_rst = 1'b0;
    @(negedge rd_clk);
  endtask

  task automatic test_basic();
    int bad;
    drive_packet(32'h010, 4, 1'b0, 0);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
    checks++; if (adr_iter0 !== 10'h010) begin failures++; $display("FAIL basic_adr_load got=%h exp=010", adr_iter0); end
    checks++; if (got_data.size() !== 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got_data.size()); end
    bad = 0;
    foreach (got_data[i]) if (got_data[i] !== exp_byte(32'h010, i) || got_last[i] !== (i == 3)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL basic_bytes got=%0d bad exp=0", bad); end
    checks++; if (first_valid_iter !== 2) begin failures++; $display("FAIL basic_first_valid got=%0d exp=2", first_valid_iter); end
    checks++; if (done_iter !== 6) begin failures++; $display("FAIL basic_done_time got=%0d exp=6", done_iter); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_wrap();
    int bad;
    drive_packet(32'h3FE, 4, 1'b0, 0);
    checks++; if (got_data.size() !== 4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", got_data.size()); end
    bad = 0;
    foreach (got_data[i]) if (got_data[i] !== exp_byte(32'h3FE, i) || got_last[i] !== (i == 3)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_bytes got=%0d bad exp=0", bad); end
    checks++; if (got_data.size() == 4 && got_data[2] !== mem[0]) begin failures++; $display("FAIL wrap_third got=%h exp=%h", got_data[2], mem[0]); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_random_ready();
    int bad, adr;
    for (int s = 0; s < 1000; s++) begin
      adr = (s * 37 + 1019) % DEPTH;
      drive_packet(adr, 6, 1'b1, 0);
      checks++; if (got_data.size() !== 6) begin failures++; $display("FAIL rnd_count pkt=%0d got=%0d exp=6", s, got_data.size()); end
      bad = 0;
      foreach (got_data[i]) if (got_data[i] !== exp_byte(adr, i) || got_last[i] !== (i == 5)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL rnd_bytes pkt=%0d got=%0d bad exp=0", s, bad); end
      checks++; if (stall_err !== 0) begin failures++; $display("FAIL rnd_stable pkt=%0d got=%0d exp=0", s, stall_err); end
      checks++; if (n_done !== 1) begin failures++; $display("FAIL rnd_done pkt=%0d got=%0d exp=1", s, n_done); end
    end
  endtask

  task automatic test_zero_len();
    drive_packet(32'h123, 0, 1'b0, 0);
    checks++; if (done_iter !== 0) begin failures++; $display("FAIL zero_done_time got=%0d exp=0", done_iter); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", n_done); end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL zero_valid got=%b exp=0", seen_valid); end
    checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", seen_busy); end
  endtask

  task automatic test_abort();
    int bad;
    drive_packet(32'h100, 8, 1'b0, 3);
    checks++; if (got_data.size() !== 3) begin failures++; $display("FAIL abort_count got=%0d exp=3", got_data.size()); end
    checks++; if (post_abort_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", post_abort_valid); end
    checks++; if (post_abort_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", post_abort_busy); end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", n_done); end
    drive_packet(32'h020, 2, 1'b0, 0);
    bad = 0;
    foreach (got_data[i]) if (got_data[i] !== exp_byte(32'h020, i) || got_last[i] !== (i == 1)) bad++;
    checks++; if (got_data.size() !== 2 || bad !== 0) begin failures++; $display("FAIL abort_next_pkt got=%0d bytes %0d bad exp=2 bytes 0 bad", got_data.size(), bad); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL abort_next_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_abort_in_idle();
    bit sv, sd, sb;
    @(negedge rd_clk);
    abort = 1'b1; start = 1'b1; start_adr = 10'h010; len = 11'd4; out_ready = 1'b1;
    @(negedge rd_clk);
    abort = 1'b0; start = 1'b0;
    sv = 0; sd = 0; sb = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) sv = 1;
      if (done) sd = 1;
      if (busy) sb = 1;
      @(negedge rd_clk);
    end
    out_ready = 1'b0;
    checks++; if (sb !== 1'b0) begin failures++; $display("FAIL idle_abort_busy got=%b exp=0", sb); end
    checks++; if (sv !== 1'b0 || sd !== 1'b0) begin failures++; $display("FAIL idle_abort_activity got=%b%b exp=00", sv, sd); end
  endtask

  task automatic test_full();
    int bad, lastc;
    drive_packet(32'h200, 1024, 1'b0, 0);
    checks++; if (got_data.size() !== 1024) begin failures++; $display("FAIL full_count got=%0d exp=1024", got_data.size()); end
    bad = 0; lastc = 0;
    foreach (got_data[i]) begin
      if (got_data[i] !== exp_byte(32'h200, i)) bad++;
      if (got_last[i] === 1'b1) lastc++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_bytes got=%0d bad exp=0", bad); end
    checks++; if (lastc !== 1 || got_last.size() != 1024 || got_last[1023] !== 1'b1) begin failures++; $display("FAIL full_last got=%0d lasts exp=1 on byte 1024", lastc); end
    checks++; if (done_iter !== 1026) begin failures++; $display("FAIL full_done_time got=%0d exp=1026", done_iter); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int qi[$];
    int dones, restart_iter, bad;
    logic busy_after;
    bit restarted;
    @(negedge rd_clk);
    start = 1'b1; start_adr = 10'h040; len = 11'd2; out_ready = 1'b1;
    @(negedge rd_clk);
    start = 1'b0;
    dones = 0; restarted = 0; restart_iter = -1; busy_after = 1'b0;
    for (int iter = 0; iter < 30; iter++) begin
      if (restarted && iter == restart_iter + 1) busy_after = busy;
      if (out_valid) begin q.push_back(out_data); qi.push_back(iter); end
      if (done) dones++;
      if (done && !restarted) begin
        start = 1'b1; start_adr = 10'h080; len = 11'd3;
        restarted = 1; restart_iter = iter;
      end else start = 1'b0;
      @(negedge rd_clk);
    end
    out_ready = 1'b0;
    bad = 0;
    if (q.size() == 5) begin
      if (q[0] !== mem[10'h040] || q[1] !== mem[10'h041]) bad++;
      for (int i = 0; i < 3; i++) if (q[2+i] !== mem[10'h080 + i]) bad++;
    end
    checks++; if (q.size() !== 5 || bad !== 0) begin failures++; $display("FAIL b2b_bytes got=%0d bytes %0d bad exp=5 bytes 0 bad", q.size(), bad); end
    checks++; if (restart_iter !== 4) begin failures++; $display("FAIL b2b_first_done got=%0d exp=4", restart_iter); end
    checks++; if (busy_after !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy_after); end
    checks++; if (qi.size() == 5 && qi[2] !== 7) begin failures++; $display("FAIL b2b_second_valid got=%0d exp=7", qi[2]); end
    checks++; if (dones !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
  endtask

  task automatic test_reset_mid();
    bit sv, sd;
    @(negedge rd_clk);
    start = 1'b1; start_adr = 10'h300; len = 11'd8; out_ready = 1'b1;
    @(negedge rd_clk);
    start = 1'b0;
    repeat (4) @(negedge rd_clk);
    rd_rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || ram_adr !== '0) begin failures++; $display("FAIL midrst_clear got=%b%b%h exp=00000", out_valid, busy, ram_adr); end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    sv = 0; sd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge rd_clk);
      if (out_valid) sv = 1;
      if (done) sd = 1;
    end
    out_ready = 1'b0;
    checks++; if (sv !== 1'b0 || sd !== 1'b0) begin failures++; $display("FAIL midrst_after got=%b%b exp=00", sv, sd); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 29 + 7 + (i >> 8) * 3);
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_abort();
    test_abort_in_idle();
    test_back_to_back();
    test_full();
    test_random_ready();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
